// File: rtl/rx_align_pkg.sv
// Shared types, widths and helpers for the receive lane alignment controller.
package rx_align_pkg;

  localparam int TAP_W     = 8;
  localparam int SLIP_W    = 2;
  localparam int MAX_RATIO = 8;
  localparam int IDX_W     = 3;

  // Top-level training sequence states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIND_START,
    ST_FIND_END,
    ST_CENTER,
    ST_ALIGN,
    ST_PASS,
    ST_FAIL
  } align_state_e;

  // Phases of one settle / sample check window.
  typedef enum logic [1:0] {
    CHK_IDLE,
    CHK_SETTLE,
    CHK_SAMPLE
  } chk_phase_e;

  // True when 'word' equals some rotation of 'pattern', both using the low
  // 'ratio' bits (upper bits are expected to be zero).
  function automatic logic is_rotation(input logic [MAX_RATIO-1:0] word,
                                       input logic [MAX_RATIO-1:0] pattern,
                                       input int ratio);
    logic                 hit;
    logic [MAX_RATIO-1:0] rot;
    hit = 1'b0;
    for (int r = 0; r < MAX_RATIO; r++) begin
      rot = '0;
      for (int i = 0; i < MAX_RATIO; i++) begin
        if (i < ratio) begin
          rot[IDX_W'(i)] = pattern[IDX_W'((i + r) % ratio)];
        end
      end
      if ((r < ratio) && (rot == word)) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/rx_lane_align_ctrl_if.sv
// Bundle of sequencer / IOD signals seen by the lane alignment controller.
interface rx_lane_align_ctrl_if #(
  parameter int RATIO = 4
);
  import rx_align_pkg::*;

  logic                  START;
  logic [RATIO-1:0]      RX_DATA;
  logic                  DELAY_LINE_OUT_OF_RANGE;
  logic                  RX_BIT_SLIP;
  logic                  DELAY_LINE_LOAD;
  logic                  DELAY_LINE_MOVE;
  logic                  DELAY_LINE_DIRECTION;
  logic                  BUSY;
  logic                  DONE;
  logic                  ERROR;
  logic [TAP_W-1:0]      TAP_OUT;
  logic [SLIP_W-1:0]     SLIP_CNT;

  // Controller side.
  modport master (
    input  START, RX_DATA, DELAY_LINE_OUT_OF_RANGE,
    output RX_BIT_SLIP, DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
    output BUSY, DONE, ERROR, TAP_OUT, SLIP_CNT
  );

  // Sequencer / IOD side.
  modport slave (
    output START, RX_DATA, DELAY_LINE_OUT_OF_RANGE,
    input  RX_BIT_SLIP, DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
    input  BUSY, DONE, ERROR, TAP_OUT, SLIP_CNT
  );

endinterface

// File: rtl/rx_align_window_chk.sv
// Settle-then-sample window checker: waits SETTLE_CYC cycles after start_chk,
// then compares SAMPLE_CYC consecutive words (loose or exact) and reports
// the verdict with a one-cycle done_chk pulse.
module rx_align_window_chk
  import rx_align_pkg::*;
#(
  parameter int               RATIO      = 4,
  parameter logic [RATIO-1:0] PATTERN    = 4'b0011,
  parameter int               SETTLE_CYC = 8,
  parameter int               SAMPLE_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_chk,
  input  logic             settle_only,
  input  logic             exact,
  input  logic [RATIO-1:0] rx_data,
  output logic             done_chk,
  output logic             pass
);

  localparam int CNT_W = 8;

  chk_phase_e       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RATIO-1:0] first_q, first_d;
  logic             ok_q, ok_d;
  logic             exact_q, exact_d;
  logic             settle_only_q, settle_only_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             word_ok;

  // Window sequencing and word comparison; the first word sets the reference
  // that every later word in the window must repeat.
  always_comb begin
    phase_d       = phase_q;
    cnt_d         = cnt_q;
    first_d       = first_q;
    ok_d          = ok_q;
    exact_d       = exact_q;
    settle_only_d = settle_only_q;
    done_d        = 1'b0;
    pass_d        = pass_q;
    word_ok       = 1'b0;

    if (cnt_q == '0) begin
      if (exact_q) begin
        word_ok = (rx_data == PATTERN);
      end else begin
        word_ok = is_rotation(MAX_RATIO'(rx_data), MAX_RATIO'(PATTERN), RATIO);
      end
    end else begin
      word_ok = (rx_data == first_q);
    end

    if (start_chk) begin
      phase_d       = CHK_SETTLE;
      cnt_d         = '0;
      exact_d       = exact;
      settle_only_d = settle_only;
    end else begin
      case (phase_q)
        CHK_IDLE: begin
          phase_d = CHK_IDLE;
        end
        CHK_SETTLE: begin
          if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
            cnt_d = '0;
            if (settle_only_q) begin
              done_d  = 1'b1;
              pass_d  = 1'b1;
              phase_d = CHK_IDLE;
            end else begin
              phase_d = CHK_SAMPLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        CHK_SAMPLE: begin
          if (cnt_q == '0) begin
            first_d = rx_data;
            ok_d    = word_ok;
          end else begin
            ok_d = ok_q & word_ok;
          end
          if (cnt_q == CNT_W'(SAMPLE_CYC - 1)) begin
            done_d  = 1'b1;
            pass_d  = ok_d;
            phase_d = CHK_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          phase_d = CHK_IDLE;
        end
      endcase
    end
  end

  // Window checker state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q       <= CHK_IDLE;
      cnt_q         <= '0;
      first_q       <= '0;
      ok_q          <= 1'b0;
      exact_q       <= 1'b0;
      settle_only_q <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      cnt_q         <= cnt_d;
      first_q       <= first_d;
      ok_q          <= ok_d;
      exact_q       <= exact_d;
      settle_only_q <= settle_only_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
    end
  end

  assign done_chk = done_q;
  assign pass     = pass_q;

endmodule

// File: rtl/rx_lane_align_ctrl.sv
// Receive lane training controller: loads the delay line, sweeps it to find
// both eye edges, walks back to the eye centre, then bit-slips until the
// deserialised word matches the training pattern.
module rx_lane_align_ctrl
  import rx_align_pkg::*;
#(
  parameter int               RATIO      = 4,
  parameter logic [RATIO-1:0] PATTERN    = 4'b0011,
  parameter int               TAP_MAX    = 127,
  parameter int               SETTLE_CYC = 8,
  parameter int               SAMPLE_CYC = 16
) (
  input  logic                 FAB_CLK,
  input  logic                 ARST,
  rx_lane_align_ctrl_if.master bus
);

  align_state_e      state_q, state_d;
  logic              wait_q, wait_d;
  logic              load_q, load_d;
  logic              move_q, move_d;
  logic              dir_q, dir_d;
  logic              slip_q, slip_d;
  logic              start_chk_q, start_chk_d;
  logic              settle_only_q, settle_only_d;
  logic              exact_q, exact_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [SLIP_W-1:0] slip_cnt_q, slip_cnt_d;
  logic [TAP_W-1:0]  tap_q, tap_d;
  logic [TAP_W-1:0]  start_tap_q, start_tap_d;
  logic [TAP_W-1:0]  end_tap_q, end_tap_d;

  logic              done_chk;
  logic              chk_pass;
  logic [TAP_W:0]    centre_sum;
  logic [TAP_W-1:0]  target;
  logic              tap_at_max;
  logic              oor;

  assign centre_sum = {1'b0, start_tap_q} + {1'b0, end_tap_q};
  assign target     = centre_sum[TAP_W:1];
  assign tap_at_max = (tap_q >= TAP_W'(TAP_MAX));
  assign oor        = bus.DELAY_LINE_OUT_OF_RANGE;

  rx_align_window_chk #(
    .RATIO      (RATIO),
    .PATTERN    (PATTERN),
    .SETTLE_CYC (SETTLE_CYC),
    .SAMPLE_CYC (SAMPLE_CYC)
  ) u_window_chk (
    .clk         (FAB_CLK),
    .rst         (ARST),
    .start_chk   (start_chk_q),
    .settle_only (settle_only_q),
    .exact       (exact_q),
    .rx_data     (bus.RX_DATA),
    .done_chk    (done_chk),
    .pass        (chk_pass)
  );

  // Next-state and pulse decisions; every pulse also launches a check window.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    load_d        = 1'b0;
    move_d        = 1'b0;
    dir_d         = 1'b0;
    slip_d        = 1'b0;
    start_chk_d   = 1'b0;
    settle_only_d = 1'b0;
    exact_d       = 1'b0;
    busy_d        = busy_q;
    done_d        = done_q;
    error_d       = error_q;
    slip_cnt_d    = slip_cnt_q;
    start_tap_d   = start_tap_q;
    end_tap_d     = end_tap_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.START && !busy_q) begin
          load_d      = 1'b1;
          start_chk_d = 1'b1;
          wait_d      = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
          slip_cnt_d  = '0;
          state_d     = ST_FIND_START;
        end
      end
      ST_FIND_START: begin
        if (wait_q && done_chk) begin
          wait_d = 1'b0;
          if (chk_pass) begin
            start_tap_d = tap_q;
            if (tap_at_max || oor) begin
              end_tap_d = tap_q;
              state_d   = ST_CENTER;
            end else begin
              move_d      = 1'b1;
              dir_d       = 1'b1;
              start_chk_d = 1'b1;
              wait_d      = 1'b1;
              state_d     = ST_FIND_END;
            end
          end else if (!tap_at_max && !oor) begin
            move_d      = 1'b1;
            dir_d       = 1'b1;
            start_chk_d = 1'b1;
            wait_d      = 1'b1;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_FIND_END: begin
        if (wait_q && done_chk) begin
          wait_d = 1'b0;
          if (!chk_pass) begin
            end_tap_d = tap_q - 1'b1;
            state_d   = ST_CENTER;
          end else if (tap_at_max || oor) begin
            end_tap_d = tap_q;
            state_d   = ST_CENTER;
          end else begin
            move_d      = 1'b1;
            dir_d       = 1'b1;
            start_chk_d = 1'b1;
            wait_d      = 1'b1;
          end
        end
      end
      ST_CENTER: begin
        if (wait_q) begin
          if (done_chk) begin
            wait_d = 1'b0;
          end
        end else if (tap_q > target) begin
          move_d        = 1'b1;
          start_chk_d   = 1'b1;
          settle_only_d = 1'b1;
          wait_d        = 1'b1;
        end else begin
          start_chk_d = 1'b1;
          exact_d     = 1'b1;
          wait_d      = 1'b1;
          state_d     = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (wait_q && done_chk) begin
          wait_d = 1'b0;
          if (chk_pass) begin
            state_d = ST_PASS;
          end else if (slip_cnt_q < SLIP_W'(RATIO - 1)) begin
            slip_d      = 1'b1;
            slip_cnt_d  = slip_cnt_q + 1'b1;
            start_chk_d = 1'b1;
            exact_d     = 1'b1;
            wait_d      = 1'b1;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_PASS: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_FAIL: begin
        error_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Tap counter follows the issued LOAD/MOVE pulses one cycle later, clamped.
  always_comb begin
    tap_d = tap_q;
    if (load_q) begin
      tap_d = '0;
    end else if (move_q && dir_q && (tap_q < TAP_W'(TAP_MAX))) begin
      tap_d = tap_q + 1'b1;
    end else if (move_q && !dir_q && (tap_q != '0)) begin
      tap_d = tap_q - 1'b1;
    end
  end

  // Controller state register; reset drops every output at once.
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      state_q       <= ST_IDLE;
      wait_q        <= 1'b0;
      load_q        <= 1'b0;
      move_q        <= 1'b0;
      dir_q         <= 1'b0;
      slip_q        <= 1'b0;
      start_chk_q   <= 1'b0;
      settle_only_q <= 1'b0;
      exact_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      slip_cnt_q    <= '0;
      tap_q         <= '0;
      start_tap_q   <= '0;
      end_tap_q     <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      load_q        <= load_d;
      move_q        <= move_d;
      dir_q         <= dir_d;
      slip_q        <= slip_d;
      start_chk_q   <= start_chk_d;
      settle_only_q <= settle_only_d;
      exact_q       <= exact_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      slip_cnt_q    <= slip_cnt_d;
      tap_q         <= tap_d;
      start_tap_q   <= start_tap_d;
      end_tap_q     <= end_tap_d;
    end
  end

  assign bus.RX_BIT_SLIP          = slip_q;
  assign bus.DELAY_LINE_LOAD      = load_q;
  assign bus.DELAY_LINE_MOVE      = move_q;
  assign bus.DELAY_LINE_DIRECTION = dir_q;
  assign bus.BUSY                 = busy_q;
  assign bus.DONE                 = done_q;
  assign bus.ERROR                = error_q;
  assign bus.TAP_OUT              = tap_q;
  assign bus.SLIP_CNT             = slip_cnt_q;

endmodule

// File: tb/tb_rx_lane_align_ctrl.sv
// Directed bench for rx_lane_align_ctrl with a behavioural lane model:
// the eye is a tap range, inside it the IOD returns the training word
// rotated by (initial rotation - slips seen), outside it returns 0000.
module tb_rx_lane_align_ctrl;
  import rx_align_pkg::*;

  localparam int         RATIO      = 4;
  localparam logic [3:0] PATTERN    = 4'b0011;
  localparam int         TAP_MAX    = 127;
  localparam int         SETTLE_CYC = 8;
  localparam int         SAMPLE_CYC = 16;
  localparam int         RUN_BOUND  = 8000;

  logic FAB_CLK = 1'b0;
  logic ARST    = 1'b1;

  rx_lane_align_ctrl_if #(.RATIO(RATIO)) bus ();

  rx_lane_align_ctrl #(
    .RATIO      (RATIO),
    .PATTERN    (PATTERN),
    .TAP_MAX    (TAP_MAX),
    .SETTLE_CYC (SETTLE_CYC),
    .SAMPLE_CYC (SAMPLE_CYC)
  ) dut (
    .FAB_CLK (FAB_CLK),
    .ARST    (ARST),
    .bus     (bus)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  int total_checks = 0;
  int bad_checks   = 0;

  int eye_lo     = 1;
  int eye_hi     = 0;
  int eye_rot    = 0;
  int oor_tap    = -1;
  int slip_base  = 0;

  int cyc           = 0;
  int up_moves      = 0;
  int down_moves    = 0;
  int loads         = 0;
  int slips         = 0;
  int wide_pulses   = 0;
  int last_slip_cyc = -100000;
  int min_slip_gap  = 100000;
  logic prev_move = 1'b0;
  logic prev_load = 1'b0;
  logic prev_slip = 1'b0;

  int base_up, base_down, base_loads, base_slips;

  logic [3:0] lane_word;

  function automatic logic [3:0] rot_left(input logic [3:0] w, input int n);
    logic [3:0] v;
    v = w;
    for (int k = 0; k < n; k++) begin
      v = {v[2:0], v[3]};
    end
    return v;
  endfunction

  // Lane model: word presented by the IOD for the current tap and slip count.
  always_comb begin
    int t;
    int r;
    t = int'(bus.TAP_OUT);
    r = (((eye_rot - (slips - slip_base)) % 4) + 4) % 4;
    if ((t >= eye_lo) && (t <= eye_hi)) begin
      lane_word = rot_left(PATTERN, r);
    end else begin
      lane_word = 4'b0000;
    end
  end

  assign bus.RX_DATA = lane_word;
  assign bus.DELAY_LINE_OUT_OF_RANGE = (oor_tap >= 0) && (int'(bus.TAP_OUT) >= oor_tap);

  // Pulse monitor: counts delay-line and slip pulses and flags stretched ones.
  always @(posedge FAB_CLK) begin
    cyc <= cyc + 1;
    if (bus.DELAY_LINE_MOVE) begin
      if (bus.DELAY_LINE_DIRECTION) up_moves <= up_moves + 1;
      else down_moves <= down_moves + 1;
    end
    if (bus.DELAY_LINE_LOAD) loads <= loads + 1;
    if (bus.RX_BIT_SLIP) begin
      slips <= slips + 1;
      if ((cyc - last_slip_cyc) < min_slip_gap) min_slip_gap <= cyc - last_slip_cyc;
      last_slip_cyc <= cyc;
    end
    if ((bus.DELAY_LINE_MOVE && prev_move) || (bus.DELAY_LINE_LOAD && prev_load) ||
        (bus.RX_BIT_SLIP && prev_slip)) begin
      wide_pulses <= wide_pulses + 1;
    end
    prev_move <= bus.DELAY_LINE_MOVE;
    prev_load <= bus.DELAY_LINE_LOAD;
    prev_slip <= bus.RX_BIT_SLIP;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
    end
  endtask

  // Configure the lane, request training, and wait (bounded) for DONE/ERROR.
  // A second START is injected after busy_start_at cycles when it is >= 0.
  task automatic applyStimulus(input string name, input int lo, input int hi,
                               input int rot, input int oor_at, input int busy_start_at);
    logic finished;
    eye_lo    = lo;
    eye_hi    = hi;
    eye_rot   = rot;
    oor_tap   = oor_at;
    slip_base = slips;
    base_up    = up_moves;
    base_down  = down_moves;
    base_loads = loads;
    base_slips = slips;
    @(posedge FAB_CLK); #1;
    bus.START = 1'b1;
    @(posedge FAB_CLK); #1;
    bus.START = 1'b0;
    checkOutput({name, " busy after start"}, int'(bus.BUSY), 1);
    checkOutput({name, " done cleared"}, int'(bus.DONE), 0);
    checkOutput({name, " error cleared"}, int'(bus.ERROR), 0);
    finished = 1'b0;
    for (int i = 0; i < RUN_BOUND; i++) begin
      @(posedge FAB_CLK); #1;
      bus.START = (i == busy_start_at);
      if (bus.DONE || bus.ERROR) begin
        finished = 1'b1;
        break;
      end
    end
    bus.START = 1'b0;
    checkOutput({name, " finished in bound"}, int'(finished), 1);
  endtask

  task automatic verifyRun(input string name, input int exp_done, input int exp_err,
                           input int exp_tap, input int exp_slip_cnt, input int exp_up,
                           input int exp_down, input int exp_slips);
    checkOutput({name, " DONE"}, int'(bus.DONE), exp_done);
    checkOutput({name, " ERROR"}, int'(bus.ERROR), exp_err);
    checkOutput({name, " BUSY"}, int'(bus.BUSY), 0);
    checkOutput({name, " TAP_OUT"}, int'(bus.TAP_OUT), exp_tap);
    checkOutput({name, " SLIP_CNT"}, int'(bus.SLIP_CNT), exp_slip_cnt);
    checkOutput({name, " up moves"}, up_moves - base_up, exp_up);
    checkOutput({name, " down moves"}, down_moves - base_down, exp_down);
    checkOutput({name, " loads"}, loads - base_loads, 1);
    checkOutput({name, " slips"}, slips - base_slips, exp_slips);
  endtask

  initial begin
    logic found;
    bus.START = 1'b0;

    // Reset state
    repeat (3) @(posedge FAB_CLK);
    #1;
    checkOutput("reset BUSY", int'(bus.BUSY), 0);
    checkOutput("reset DONE", int'(bus.DONE), 0);
    checkOutput("reset ERROR", int'(bus.ERROR), 0);
    checkOutput("reset TAP_OUT", int'(bus.TAP_OUT), 0);
    checkOutput("reset SLIP_CNT", int'(bus.SLIP_CNT), 0);
    checkOutput("reset LOAD", int'(bus.DELAY_LINE_LOAD), 0);
    checkOutput("reset MOVE", int'(bus.DELAY_LINE_MOVE), 0);
    checkOutput("reset SLIP", int'(bus.RX_BIT_SLIP), 0);
    ARST = 1'b0;
    repeat (2) @(posedge FAB_CLK);

    // Eye 10..30, aligned word: centre (10+30)/2 = 20
    $display("[TB] eye 10..30 rotation 0");
    applyStimulus("t1", 10, 30, 0, -1, -1);
    verifyRun("t1", 1, 0, 20, 0, 31, 11, 0);
    repeat (20) @(posedge FAB_CLK);
    #1;
    checkOutput("t1 DONE held", int'(bus.DONE), 1);

    // Same eye, word arrives rotated by 2: two slips needed
    $display("[TB] eye 10..30 rotation 2");
    applyStimulus("t2", 10, 30, 2, -1, -1);
    verifyRun("t2", 1, 0, 20, 2, 31, 11, 2);
    checkOutput("t2 slip spacing ok", int'(min_slip_gap >= SETTLE_CYC + SAMPLE_CYC), 1);

    // No eye anywhere: full sweep then error
    $display("[TB] no eye");
    applyStimulus("t3", 1, 0, 0, -1, -1);
    verifyRun("t3", 0, 1, 127, 0, 127, 0, 0);

    // Eye reaching the end stop: end=127, centre (100+127)>>1 = 113
    $display("[TB] eye 100..127");
    applyStimulus("t4", 100, 127, 0, -1, -1);
    verifyRun("t4", 1, 0, 113, 0, 127, 14, 0);

    // No eye, delay line reports out-of-range from tap 60
    $display("[TB] no eye, out of range at 60");
    applyStimulus("t5", 1, 0, 0, 60, -1);
    verifyRun("t5", 0, 1, 60, 0, 60, 0, 0);
    oor_tap = -1;

    // Asynchronous reset in the middle of the end-edge sweep
    $display("[TB] reset mid-sweep");
    eye_lo  = 10;
    eye_hi  = 30;
    eye_rot = 0;
    @(posedge FAB_CLK); #1;
    bus.START = 1'b1;
    @(posedge FAB_CLK); #1;
    bus.START = 1'b0;
    found = 1'b0;
    for (int i = 0; i < RUN_BOUND; i++) begin
      @(posedge FAB_CLK); #1;
      if (bus.TAP_OUT == 8'd15) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("t6 reached tap 15", int'(found), 1);
    #2;
    ARST = 1'b1;
    #1;
    checkOutput("t6 async BUSY", int'(bus.BUSY), 0);
    checkOutput("t6 async TAP_OUT", int'(bus.TAP_OUT), 0);
    checkOutput("t6 async MOVE", int'(bus.DELAY_LINE_MOVE), 0);
    checkOutput("t6 async DIRECTION", int'(bus.DELAY_LINE_DIRECTION), 0);
    checkOutput("t6 async LOAD", int'(bus.DELAY_LINE_LOAD), 0);
    checkOutput("t6 async DONE", int'(bus.DONE), 0);
    checkOutput("t6 async ERROR", int'(bus.ERROR), 0);
    repeat (3) @(posedge FAB_CLK);
    #1;
    ARST = 1'b0;
    base_up    = up_moves;
    base_down  = down_moves;
    base_loads = loads;
    repeat (40) @(posedge FAB_CLK);
    #1;
    checkOutput("t6 idle after reset loads", loads - base_loads, 0);
    checkOutput("t6 idle after reset moves", (up_moves - base_up) + (down_moves - base_down), 0);
    checkOutput("t6 idle after reset BUSY", int'(bus.BUSY), 0);

    // Restart; a START issued while BUSY must change nothing
    applyStimulus("t6", 10, 30, 0, -1, 50);
    verifyRun("t6", 1, 0, 20, 0, 31, 11, 0);

    checkOutput("stretched pulses", wide_pulses, 0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

  // Last-resort guard in case something above never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/rx_lane_align_ctrl.md
Name: rx_lane_align_ctrl

Overview:
- Receive-side training controller for one DDR PHY input lane, driving an input IOD with a 4:1 deserialiser and dynamic delay line.
- Loads the delay line, sweeps taps to find the eye edges, centres on the eye, then issues bit-slips until the deserialised word matches the training pattern.
- Runs in the FAB_CLK domain, between the IOD RX_DATA / delay-line ports and the PHY training sequencer.

Parameters:
- RATIO, 4: deserialisation ratio and RX_DATA width.
- PATTERN, 4'b0011: expected training word after alignment; all RATIO rotations are distinct.
- TAP_MAX, 127: highest delay-line tap.
- SETTLE_CYC, 8: wait cycles after any LOAD, MOVE or SLIP before sampling.
- SAMPLE_CYC, 16: consecutive words compared per check window.

Ports:
- FAB_CLK  in  1  fabric clock.
- ARST  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle training request.
- RX_DATA  in  RATIO  deserialised word from the IOD.
- DELAY_LINE_OUT_OF_RANGE  in  1  delay line at its end stop.
- RX_BIT_SLIP  out  1  one-cycle slip pulse.
- DELAY_LINE_LOAD  out  1  one-cycle load pulse; tap returns to 0.
- DELAY_LINE_MOVE  out  1  one-cycle move pulse.
- DELAY_LINE_DIRECTION  out  1  1 = increment, 0 = decrement; valid with MOVE.
- BUSY  out  1  training in progress.
- DONE  out  1  training succeeded; held until next START.
- ERROR  out  1  training failed; held until next START.
- TAP_OUT  out  8  current tap count.
- SLIP_CNT  out  2  slips issued.

Behaviour:
- Reset: all outputs 0, state IDLE, tap/start/end registers 0. ARST mid-operation aborts immediately; the delay line is not touched until the next START issues a LOAD.
- START is honoured only when BUSY=0. It clears DONE, ERROR and SLIP_CNT.
- Every pulse output is exactly one cycle long. Each pulse is followed by SETTLE_CYC idle cycles, then a check window.
- Check window: SAMPLE_CYC cycles.
  - "Loose pass": the first word is any rotation of PATTERN and every later word equals that first word.
  - "Exact pass": every word equals PATTERN.
- States:
  - IDLE: on START, pulse LOAD, set tap=0, BUSY=1, go to FIND_START.
  - FIND_START: settle, then loose check. On pass, start=tap and go to FIND_END. On fail with tap<TAP_MAX and no OUT_OF_RANGE, MOVE up, tap+1. Otherwise go to FAIL.
  - FIND_END: MOVE up, tap+1, settle, loose check. On fail, end=tap-1 and go to CENTER. If the check passes and tap==TAP_MAX or OUT_OF_RANGE=1, end=tap and go to CENTER.
  - CENTER: target=(start+end)>>1, computed with a 9-bit sum and floor. Issue (tap-target) MOVE pulses with DIRECTION=0, each followed by a settle. Then go to ALIGN.
  - ALIGN: exact check. On pass, go to PASS. On fail with SLIP_CNT<RATIO-1, pulse SLIP, SLIP_CNT+1, settle, recheck. Otherwise go to FAIL.
  - PASS: DONE=1, BUSY=0, go to IDLE.
  - FAIL: ERROR=1, BUSY=0, go to IDLE.
- TAP_OUT tracks every MOVE in the cycle after the pulse, saturating at 0 and TAP_MAX.
- DELAY_LINE_OUT_OF_RANGE is sampled only in the FIND_START and FIND_END decisions.
- Single-tap eye (start==end) is legal; the centre is start.

Decomposition:
- Shared package (rx_align_pkg) holds:
  - the state enum;
  - TAP_W=8 and SLIP_W=2;
  - a rotate-compare function for RATIO-bit words.
- One sub-module: rx_align_window_chk. It contains the settle counter, the sample counter, and loose/exact compare. Handshake is start_chk → done_chk, with a pass output.

Test Plan:
- Lane model passes rotation 0 for taps 10..30, garbage elsewhere; START → 31 up-MOVEs, 11 down-MOVEs, DONE=1, TAP_OUT=20, SLIP_CNT=0, no SLIP pulse.
- Same eye with rotation 2 → 2 SLIP pulses at least SETTLE_CYC+SAMPLE_CYC apart, DONE=1, SLIP_CNT=2.
- No eye at any tap → 127 up-MOVEs, ERROR=1, DONE=0, TAP_OUT=127.
- Eye at taps 100..127 → end=127, 14 down-MOVEs, TAP_OUT=113, DONE=1.
- No eye, OUT_OF_RANGE forced high at tap 60 → ERROR=1, TAP_OUT=60, no further MOVE.
- ARST at tap 15 mid-sweep → all outputs 0 the same cycle. Next START → exactly one LOAD pulse, then the test-1 result. A START while BUSY is ignored.
